// File: rtl/core2axi_mo.sv
// Bridge from the core's OBI-style data port to a single-beat AXI4 master.
// Multiple transactions of one type may be in flight; responses return in order.
module core2axi_mo #(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH    = 32,
  parameter int unsigned AXI4_ID_WIDTH      = 4,
  parameter int unsigned AXI4_USER_WIDTH    = 10,
  parameter int unsigned MAX_OUTSTANDING    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          data_req_i,
  output logic                          data_gnt_o,
  output logic                          data_rvalid_o,
  input  logic [31:0]                   data_addr_i,
  input  logic                          data_we_i,
  input  logic [3:0]                    data_be_i,
  input  logic [31:0]                   data_wdata_i,
  output logic [31:0]                   data_rdata_o,
  output logic                          data_err_o,
  output logic [AXI4_ID_WIDTH-1:0]      aw_id_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_o,
  output logic [7:0]                    aw_len_o,
  output logic [2:0]                    aw_size_o,
  output logic [1:0]                    aw_burst_o,
  output logic                          aw_lock_o,
  output logic [3:0]                    aw_cache_o,
  output logic [2:0]                    aw_prot_o,
  output logic [3:0]                    aw_region_o,
  output logic [AXI4_USER_WIDTH-1:0]    aw_user_o,
  output logic [3:0]                    aw_qos_o,
  output logic                          aw_valid_o,
  input  logic                          aw_ready_i,
  output logic [AXI4_DATA_WIDTH-1:0]    w_data_o,
  output logic [AXI4_DATA_WIDTH/8-1:0]  w_strb_o,
  output logic                          w_last_o,
  output logic [AXI4_USER_WIDTH-1:0]    w_user_o,
  output logic                          w_valid_o,
  input  logic                          w_ready_i,
  input  logic [AXI4_ID_WIDTH-1:0]      b_id_i,
  input  logic [1:0]                    b_resp_i,
  input  logic                          b_valid_i,
  input  logic [AXI4_USER_WIDTH-1:0]    b_user_i,
  output logic                          b_ready_o,
  output logic [AXI4_ID_WIDTH-1:0]      ar_id_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr_o,
  output logic [7:0]                    ar_len_o,
  output logic [2:0]                    ar_size_o,
  output logic [1:0]                    ar_burst_o,
  output logic                          ar_lock_o,
  output logic [3:0]                    ar_cache_o,
  output logic [2:0]                    ar_prot_o,
  output logic [3:0]                    ar_region_o,
  output logic [AXI4_USER_WIDTH-1:0]    ar_user_o,
  output logic [3:0]                    ar_qos_o,
  output logic                          ar_valid_o,
  input  logic                          ar_ready_i,
  input  logic [AXI4_ID_WIDTH-1:0]      r_id_i,
  input  logic [AXI4_DATA_WIDTH-1:0]    r_data_i,
  input  logic [1:0]                    r_resp_i,
  input  logic                          r_last_i,
  input  logic [AXI4_USER_WIDTH-1:0]    r_user_i,
  input  logic                          r_valid_i,
  output logic                          r_ready_o
);

  localparam int unsigned LANES     = AXI4_DATA_WIDTH / 32;
  localparam int unsigned LANE_BITS = $clog2(LANES);
  localparam int unsigned LW        = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int unsigned CW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned STRB_W    = AXI4_DATA_WIDTH / 8;

  if (!(AXI4_DATA_WIDTH == 32 || AXI4_DATA_WIDTH == 64 || AXI4_DATA_WIDTH == 128)) begin : g_bad_width
    $error("core2axi_mo: AXI4_DATA_WIDTH must be 32, 64 or 128");
  end
  if (MAX_OUTSTANDING < 1 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_outstanding
    $error("core2axi_mo: MAX_OUTSTANDING must be a power of two");
  end

  typedef enum logic {READ = 1'b0, WRITE = 1'b1} mode_e;

  mode_e          mode_q, mode_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           aw_done_q, aw_done_d;
  logic           w_done_q, w_done_d;
  logic [LW-1:0]  lane_fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;

  logic [LW-1:0]  lane;
  logic [LW-1:0]  lane_head;
  logic           eligible, aw_hs, w_hs, rd_gnt, wr_gnt, r_hs, b_hs;

  if (LANE_BITS > 0) begin : g_lane
    assign lane = data_addr_i[LANE_BITS+1:2];
  end else begin : g_no_lane
    assign lane = '0;
  end

  assign aw_id_o     = '0;
  assign aw_addr_o   = AXI4_ADDRESS_WIDTH'(data_addr_i);
  assign aw_len_o    = 8'd0;
  assign aw_size_o   = 3'b010;
  assign aw_burst_o  = 2'b01;
  assign aw_lock_o   = 1'b0;
  assign aw_cache_o  = 4'd0;
  assign aw_prot_o   = 3'd0;
  assign aw_region_o = 4'd0;
  assign aw_user_o   = '0;
  assign aw_qos_o    = 4'd0;
  assign ar_id_o     = '0;
  assign ar_addr_o   = AXI4_ADDRESS_WIDTH'(data_addr_i);
  assign ar_len_o    = 8'd0;
  assign ar_size_o   = 3'b010;
  assign ar_burst_o  = 2'b01;
  assign ar_lock_o   = 1'b0;
  assign ar_cache_o  = 4'd0;
  assign ar_prot_o   = 3'd0;
  assign ar_region_o = 4'd0;
  assign ar_user_o   = '0;
  assign ar_qos_o    = 4'd0;
  assign w_last_o    = 1'b1;
  assign w_user_o    = '0;
  assign w_data_o    = {LANES{data_wdata_i}};
  assign w_strb_o    = STRB_W'(data_be_i) << {lane, 2'b00};

  // A new request must match the type of what is already in flight.
  assign eligible   = data_req_i && (cnt_q < CW'(MAX_OUTSTANDING)) &&
                      ((cnt_q == '0) || (data_we_i == (mode_q == WRITE)));
  assign ar_valid_o = eligible & ~data_we_i;
  assign aw_valid_o = eligible & data_we_i & ~aw_done_q;
  assign w_valid_o  = eligible & data_we_i & ~w_done_q;

  assign aw_hs      = aw_valid_o & aw_ready_i;
  assign w_hs       = w_valid_o & w_ready_i;
  assign rd_gnt     = ar_valid_o & ar_ready_i;
  assign wr_gnt     = eligible & data_we_i & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign data_gnt_o = rd_gnt | wr_gnt;

  assign r_ready_o     = (cnt_q != '0) && (mode_q == READ);
  assign b_ready_o     = (cnt_q != '0) && (mode_q == WRITE);
  assign r_hs          = r_valid_i & r_ready_o;
  assign b_hs          = b_valid_i & b_ready_o;
  assign data_rvalid_o = r_hs | b_hs;
  assign data_err_o    = (r_hs & r_resp_i[1]) | (b_hs & b_resp_i[1]);
  assign lane_head     = lane_fifo_q[rd_ptr_q];
  assign data_rdata_o  = r_data_i[{lane_head, 5'b00000} +: 32];

  always_comb begin
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (data_gnt_o && !data_rvalid_o) cnt_d = cnt_q + CW'(1);
    else if (!data_gnt_o && data_rvalid_o) cnt_d = cnt_q - CW'(1);
    if (data_gnt_o) mode_d = data_we_i ? WRITE : READ;
    if (wr_gnt) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (aw_hs) aw_done_d = 1'b1;
      if (w_hs)  w_done_d  = 1'b1;
    end
  end

  // Lane FIFO pushes on read grant and pops on read response; both may happen together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      mode_q    <= READ;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) lane_fifo_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (rd_gnt) begin
        lane_fifo_q[wr_ptr_q] <= lane;
        wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (r_hs) begin
        rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{b_id_i, b_user_i, r_id_i, r_user_i, r_last_i, r_resp_i[0], b_resp_i[0]};

endmodule

// File: tb/tb_core2axi_mo.sv
// Directed scoreboard bench for core2axi_mo on a 64-bit bus with four outstanding.
module tb_core2axi_mo;
  localparam int DW = 64;
  localparam int MO = 4;
  localparam int IW = 4;
  localparam int UW = 10;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [31:0]   data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]    data_be_i;
  logic [IW-1:0] aw_id_o, ar_id_o, b_id_i, r_id_i;
  logic [31:0]   aw_addr_o, ar_addr_o;
  logic [7:0]    aw_len_o, ar_len_o;
  logic [2:0]    aw_size_o, ar_size_o, aw_prot_o, ar_prot_o;
  logic [1:0]    aw_burst_o, ar_burst_o, b_resp_i, r_resp_i;
  logic          aw_lock_o, ar_lock_o, aw_valid_o, ar_valid_o, aw_ready_i, ar_ready_i;
  logic [3:0]    aw_cache_o, ar_cache_o, aw_region_o, ar_region_o, aw_qos_o, ar_qos_o;
  logic [UW-1:0] aw_user_o, ar_user_o, w_user_o, b_user_i, r_user_i;
  logic [DW-1:0] w_data_o, r_data_i;
  logic [DW/8-1:0] w_strb_o;
  logic          w_last_o, w_valid_o, w_ready_i, b_valid_i, b_ready_o;
  logic          r_last_i, r_valid_i, r_ready_o;

  typedef struct packed {
    logic        isWrite;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  logic granted5;

  core2axi_mo #(
    .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW),
    .AXI4_USER_WIDTH(UW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
    .aw_burst_o(aw_burst_o), .aw_lock_o(aw_lock_o), .aw_cache_o(aw_cache_o),
    .aw_prot_o(aw_prot_o), .aw_region_o(aw_region_o), .aw_user_o(aw_user_o),
    .aw_qos_o(aw_qos_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o), .w_user_o(w_user_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .b_id_i(b_id_i), .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_user_i(b_user_i),
    .b_ready_o(b_ready_o),
    .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
    .ar_burst_o(ar_burst_o), .ar_lock_o(ar_lock_o), .ar_cache_o(ar_cache_o),
    .ar_prot_o(ar_prot_o), .ar_region_o(ar_region_o), .ar_user_o(ar_user_o),
    .ar_qos_o(ar_qos_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .r_id_i(r_id_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i),
    .r_user_i(r_user_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] ctrlVec();
    return {data_gnt_o, data_rvalid_o, data_err_o, aw_valid_o,
            w_valid_o, ar_valid_o, r_ready_o, b_ready_o};
  endfunction

  function automatic logic [31:0] laneOf(input logic [63:0] d, input logic [31:0] a);
    return a[2] ? d[63:32] : d[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata);
    data_req_i   = req;
    data_we_i    = we;
    data_addr_i  = addr;
    data_be_i    = be;
    data_wdata_i = wdata;
  endtask

  // Any forwarded response must match the oldest scoreboard entry.
  task automatic observeResponse(input string tag, input logic expValid);
    exp_t e;
    checkOutput({tag, "_rvalid"}, 64'(data_rvalid_o), 64'(expValid));
    if (data_rvalid_o) begin
      if (sbQ.size() == 0) begin
        checkOutput({tag, "_sb_nonempty"}, 64'(sbQ.size() != 0), 64'd1);
      end else begin
        e = sbQ.pop_front();
        checkOutput({tag, "_err"}, 64'(data_err_o), 64'(e.err));
        if (!e.isWrite) checkOutput({tag, "_rdata"}, 64'(data_rdata_o), 64'(e.rdata));
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    {aw_ready_i, w_ready_i, ar_ready_i, b_valid_i, r_valid_i, r_last_i} = '0;
    b_resp_i = 2'b00; r_resp_i = 2'b00; b_id_i = '0; r_id_i = '0;
    b_user_i = '0; r_user_i = '0;
    r_data_i = 64'hAAAABBBB_CCCCDDDD;

    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("reset_ctrl", 64'(ctrlVec()), 64'h0);
    checkOutput("reset_rdata", 64'(data_rdata_o), 64'hCCCCDDDD);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("idle_ctrl", 64'(ctrlVec()), 64'h0);

    // Pipelined reads: four accepted, the fifth stalls until a response frees a slot.
    ar_ready_i = 1'b1;
    r_data_i   = 64'h11111111_22222222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      applyStimulus(1'b1, 1'b0, 32'(4 * i), 4'hF, 32'h0);
      #1;
      checkOutput($sformatf("rd%0d_gnt", i), 64'(data_gnt_o), 64'(i < 4));
      checkOutput($sformatf("rd%0d_arvalid", i), 64'(ar_valid_o), 64'(i < 4));
      if (i == 2) checkOutput("rd2_araddr", 64'(ar_addr_o), 64'h8);
      if (i < 4) sbQ.push_back('{1'b0, 1'b0, laneOf(r_data_i, 32'(4 * i))});
    end
    checkOutput("rd_full_rready", 64'(r_ready_o), 64'd1);

    granted5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      if (granted5) applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      r_valid_i = 1'b1;
      r_resp_i  = 2'b00;
      #1;
      if (!granted5 && data_gnt_o) begin
        granted5 = 1'b1;
        sbQ.push_back('{1'b0, 1'b0, laneOf(r_data_i, 32'h10)});
      end
      observeResponse($sformatf("rdrsp%0d", k), 1'b1);
    end
    checkOutput("rd5_granted", 64'(granted5), 64'd1);
    @(negedge clk_i);
    r_valid_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    checkOutput("rd_drained_rready", 64'(r_ready_o), 64'd0);

    // Write with AW held off: W goes first and must not be re-sent.
    @(negedge clk_i);
    ar_ready_i = 1'b0; aw_ready_i = 1'b0; w_ready_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h104, 4'b0011, 32'hDEADBEEF);
    #1;
    checkOutput("wr_c0_awvalid", 64'(aw_valid_o), 64'd1);
    checkOutput("wr_c0_wvalid", 64'(w_valid_o), 64'd1);
    checkOutput("wr_c0_gnt", 64'(data_gnt_o), 64'd0);
    checkOutput("wr_strb", 64'(w_strb_o), 64'h30);
    checkOutput("wr_wdata", 64'(w_data_o), 64'hDEADBEEF_DEADBEEF);
    checkOutput("wr_awaddr", 64'(aw_addr_o), 64'h104);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk_i);
      #1;
      checkOutput($sformatf("wr_c%0d_wvalid", c), 64'(w_valid_o), 64'd0);
      checkOutput($sformatf("wr_c%0d_gnt", c), 64'(data_gnt_o), 64'd0);
    end
    @(negedge clk_i);
    aw_ready_i = 1'b1;
    #1;
    checkOutput("wr_c3_gnt", 64'(data_gnt_o), 64'd1);
    checkOutput("wr_c3_wvalid", 64'(w_valid_o), 64'd0);
    sbQ.push_back('{1'b1, 1'b0, 32'h0});
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    b_valid_i = 1'b1; b_resp_i = 2'b00;
    #1;
    checkOutput("wr_bready", 64'(b_ready_o), 64'd1);
    observeResponse("wr_b", 1'b1);
    @(negedge clk_i);
    b_valid_i = 1'b0;

    // Type switch: a read waits for both B responses; first B carries SLVERR.
    ar_ready_i = 1'b1; w_ready_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h200, 4'b1100, 32'h12345678);
    #1;
    checkOutput("sw_w0_gnt", 64'(data_gnt_o), 64'd1);
    checkOutput("sw_w0_strb", 64'(w_strb_o), 64'h0C);
    sbQ.push_back('{1'b1, 1'b1, 32'h0});
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b1, 32'h20C, 4'hF, 32'hCAFEF00D);
    #1;
    checkOutput("sw_w1_gnt", 64'(data_gnt_o), 64'd1);
    checkOutput("sw_w1_strb", 64'(w_strb_o), 64'hF0);
    sbQ.push_back('{1'b1, 1'b0, 32'h0});
    @(negedge clk_i);
    applyStimulus(1'b1, 1'b0, 32'h300, 4'hF, 32'h0);
    #1;
    checkOutput("sw_rd_stall0", 64'({ar_valid_o, data_gnt_o}), 64'd0);
    @(negedge clk_i);
    b_valid_i = 1'b1; b_resp_i = 2'b10;
    #1;
    checkOutput("sw_rd_stall1", 64'(ar_valid_o), 64'd0);
    observeResponse("sw_b0", 1'b1);
    @(negedge clk_i);
    b_resp_i = 2'b00;
    #1;
    checkOutput("sw_rd_stall2", 64'(ar_valid_o), 64'd0);
    observeResponse("sw_b1", 1'b1);
    @(negedge clk_i);
    b_valid_i = 1'b0;
    #1;
    checkOutput("sw_rd_arvalid", 64'(ar_valid_o), 64'd1);
    checkOutput("sw_rd_gnt", 64'(data_gnt_o), 64'd1);
    sbQ.push_back('{1'b0, 1'b0, laneOf(r_data_i, 32'h300)});
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    r_valid_i = 1'b1; r_resp_i = 2'b01;
    #1;
    checkOutput("sw_bready_low", 64'(b_ready_o), 64'd0);
    observeResponse("sw_r_exokay", 1'b1);
    @(negedge clk_i);
    r_valid_i = 1'b0; r_resp_i = 2'b00;

    // Stray responses with nothing outstanding are ignored.
    r_valid_i = 1'b1; b_valid_i = 1'b1;
    #1;
    checkOutput("stray_readies", 64'({r_ready_o, b_ready_o}), 64'd0);
    observeResponse("stray", 1'b0);
    @(negedge clk_i);
    r_valid_i = 1'b0; b_valid_i = 1'b0;

    // Three reads in flight, then reset drops them.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk_i);
      applyStimulus(1'b1, 1'b0, 32'(32'h40 + 4 * i), 4'hF, 32'h0);
      #1;
      checkOutput($sformatf("pre_rst%0d_gnt", i), 64'(data_gnt_o), 64'd1);
    end
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst_ni = 1'b0;
    r_valid_i = 1'b1;
    #1;
    checkOutput("in_rst_ctrl", 64'(ctrlVec()), 64'h0);
    @(negedge clk_i);
    #1;
    checkOutput("in_rst_ctrl_next", 64'(ctrlVec()), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("post_rst_rready", 64'(r_ready_o), 64'd0);
    observeResponse("post_rst_stray", 1'b0);
    @(negedge clk_i);
    r_valid_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
    #1;
    checkOutput("post_rst_gnt", 64'(data_gnt_o), 64'd1);
    sbQ.push_back('{1'b0, 1'b0, laneOf(r_data_i, 32'h4)});
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    r_valid_i = 1'b1;
    #1;
    observeResponse("post_rst_rd", 1'b1);
    @(negedge clk_i);
    r_valid_i = 1'b0;
    checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
